// File: rtl/ibis_video_pkg.sv
// ibis_video_pkg: shared raster timing types for the video timing generator
package ibis_video_pkg;
    localparam int COORD_W = 12;
    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;
    typedef struct packed {
        logic [COORD_W-1:0] active;
        logic [COORD_W-1:0] front;
        logic [COORD_W-1:0] sync;
        logic [COORD_W-1:0] back;
    } timing_t;
endpackage

// File: rtl/ibis_timing_axis.sv
// ibis_timing_axis: one raster axis counter with phase decode and wrap strobe
module ibis_timing_axis
    import ibis_video_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  timing_t            timing,
    input  logic               step,
    input  logic               clear,
    output logic [COORD_W-1:0] count,
    output phase_t             phase,
    output logic               wrap
);
    logic [COORD_W:0] pos, a_end, f_end, s_end, last;
    assign pos   = {1'b0, count};
    assign a_end = {1'b0, timing.active};
    assign f_end = a_end + {1'b0, timing.front};
    assign s_end = f_end + {1'b0, timing.sync};
    assign last  = s_end + {1'b0, timing.back} - (COORD_W+1)'(1);
    assign wrap  = step && !clear && pos == last;
    always_comb phase = pos < a_end ? PH_ACTIVE : pos < f_end ? PH_FRONT : pos < s_end ? PH_SYNC : PH_BACK;
    // a clear that coincides with a step already consumes position 0
    always_ff @(posedge aclk)
        if (!aresetn) count <= '0;
        else if (clear) count <= step ? COORD_W'(1) : '0;
        else if (step) count <= pos == last ? '0 : count + COORD_W'(1);
endmodule

// File: rtl/ibis_video_timing.sv
// ibis_video_timing: raster timing generator feeding the TMDS encoders
module ibis_video_timing
    import ibis_video_pkg::*;
#(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               enable,
    input  logic               restart,
    output logic               data_enable,
    output logic [1:0]         control,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_params
            $error("ibis_video_timing: illegal timing parameters");
        end
    endgenerate
    localparam timing_t H_T = '{COORD_W'(H_ACTIVE), COORD_W'(H_FRONT), COORD_W'(H_SYNC), COORD_W'(H_BACK)};
    localparam timing_t V_T = '{COORD_W'(V_ACTIVE), COORD_W'(V_FRONT), COORD_W'(V_SYNC), COORD_W'(V_BACK)};
    logic [COORD_W-1:0] h_count, v_count;
    phase_t h_phase, v_phase;
    logic h_wrap, v_wrap, clear, origin;
    assign clear = enable && restart;
    ibis_timing_axis u_h (
        .aclk(aclk), .aresetn(aresetn), .timing(H_T), .step(enable), .clear(clear),
        .count(h_count), .phase(h_phase), .wrap(h_wrap)
    );
    ibis_timing_axis u_v (
        .aclk(aclk), .aresetn(aresetn), .timing(V_T), .step(h_wrap), .clear(clear),
        .count(v_count), .phase(v_phase), .wrap(v_wrap)
    );
    // origin: counters sit at (0,0), true after reset or a full-frame wrap
    always_ff @(posedge aclk)
        if (!aresetn) begin
            origin      <= 1'b1;
            data_enable <= 1'b0;
            control     <= {~V_SYNC_POL, ~H_SYNC_POL};
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            origin      <= v_wrap;
            data_enable <= restart || (h_phase == PH_ACTIVE && v_phase == PH_ACTIVE);
            control     <= restart ? {~V_SYNC_POL, ~H_SYNC_POL}
                         : {v_phase == PH_SYNC ? V_SYNC_POL : ~V_SYNC_POL, h_phase == PH_SYNC ? H_SYNC_POL : ~H_SYNC_POL};
            x           <= restart ? '0 : h_count;
            y           <= restart ? '0 : v_count;
            line_start  <= restart || h_count == '0;
            frame_start <= restart || origin;
        end
endmodule

// File: tb/tb_ibis_video_timing.sv
// tb_ibis_video_timing: directed checks of the raster generator on a 15x8 raster
module tb_ibis_video_timing;
    logic aclk = 1'b0, aresetn, enable, restart;
    logic data_enable, line_start, frame_start;
    logic [1:0] control;
    logic [11:0] x, y;
    int tests = 0, fails = 0;
    int px, py, de_cnt, fs_cnt;

    ibis_video_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .restart(restart),
        .data_enable(data_enable), .control(control), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        if (px == 14) begin
            px = 0;
            py = (py == 7) ? 0 : py + 1;
        end else px++;
    endtask

    task automatic check_pos(input string tag);
        chk({tag, "_x"}, x, px);
        chk({tag, "_y"}, y, py);
        chk({tag, "_de"}, data_enable, px < 8 && py < 4);
        chk({tag, "_ctrl"}, control, {!(py >= 5 && py <= 6), !(px >= 10 && px <= 12)});
        chk({tag, "_ls"}, line_start, px == 0);
        chk({tag, "_fs"}, frame_start, px == 0 && py == 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_de"}, data_enable, 0);
        chk({tag, "_ctrl"}, control, 2'b11);
        chk({tag, "_ls"}, line_start, 0);
        chk({tag, "_fs"}, frame_start, 0);
    endtask

    task automatic run_to(input int tx, input int ty);
        enable = 1'b1;
        for (int i = 0; i < 200 && !(px == tx && py == ty); i++) begin
            advance();
            tick();
            check_pos("seek");
        end
        chk("seek_x", x, tx);
        chk("seek_y", y, ty);
    endtask

    initial begin
        aresetn = 1'b0; enable = 1'b1; restart = 1'b0; px = 0; py = 0;
        repeat (5) begin
            tick();
            check_reset("rst");
        end
        aresetn = 1'b1;
        tick();
        check_pos("first");
        chk("first_fs", frame_start, 1);
        de_cnt = int'(data_enable);
        fs_cnt = int'(frame_start);
        repeat (239) begin
            advance();
            tick();
            check_pos("run");
            de_cnt += int'(data_enable);
            fs_cnt += int'(frame_start);
        end
        chk("de_per_2frames", de_cnt, 64);
        chk("fs_per_2frames", fs_cnt, 2);
        chk("prewrap_x", x, 14);
        chk("prewrap_y", y, 7);
        advance();
        tick();
        check_pos("wrap");
        chk("wrap_fs", frame_start, 1);
        repeat (40) begin
            enable = 1'b0;
            repeat (3) begin
                tick();
                check_pos("hold");
            end
            enable = 1'b1;
            advance();
            tick();
            check_pos("slow");
        end
        run_to(5, 2);
        enable = 1'b0; restart = 1'b1;
        tick();
        check_pos("restart_ignored");
        enable = 1'b1;
        tick();
        px = 0; py = 0;
        check_pos("restart");
        chk("restart_fs", frame_start, 1);
        restart = 1'b0;
        px = 1;
        tick();
        check_pos("after_restart");
        run_to(9, 3);
        aresetn = 1'b0;
        tick();
        check_reset("midrst");
        aresetn = 1'b1;
        px = 0; py = 0;
        tick();
        check_pos("post_rst");
        px = 1;
        tick();
        check_pos("post_rst2");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
